// File: rtl/game_pkg.sv
// game_pkg
//  Shared types and constants for the tank-game flow controller.
//  - state_e : 2-bit game-flow state (MENU, PLAY, PAUSE, OVER)
//  - BTN_*   : bit positions of the four buttons in the edge-detect vector
package game_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_MENU  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int N_BTN     = 4;
    localparam int BTN_START = 0;
    localparam int BTN_SEL   = 1;
    localparam int BTN_PAUSE = 2;
    localparam int BTN_RET   = 3;

endpackage

// File: rtl/game_fsm_ctrl_btn_edge.sv
// btn_edge
//  Rising-edge detector for one already-synchronised button level. A held
//  level produces exactly one single-cycle pulse.
//  Ports: clk, rst (sync, active high), lvl (button level) -> pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic pulse
);

    logic lvl_q;
    logic lvl_d;

    always_comb begin
        lvl_d = lvl;
    end

    always_ff @(posedge clk) begin
        if (rst) lvl_q <= 1'b0;
        else     lvl_q <= lvl_d;
    end

    assign pulse = lvl & ~lvl_q;

endmodule

// File: rtl/game_fsm_ctrl.sv
// game_fsm_ctrl
//  Game-flow controller: MENU -> PLAY <-> PAUSE, PLAY -> OVER -> MENU.
//  Selects one of NUM_GAMES variants and drives all object, music and reward
//  enables plus a start-protect window of PROTECT_CYCLES PLAY cycles.
//  Ports:
//   clk, rst                  clock, synchronous active-high reset
//   btn_start/sel/pause/return button levels (edge detected internally)
//   gameover[NUM_GAMES]       per-variant game-over flags
//   state, game_sel           current state / selected variant
//   enable_*                  registered enables (1 cycle behind state)
//   start_protect             player invulnerability window
module game_fsm_ctrl
    import game_pkg::*;
#(
    parameter  int NUM_GAMES      = 2,
    parameter  int N_ENY          = 4,
    parameter  int PROTECT_CYCLES = 300000000,
    localparam int GW             = (NUM_GAMES > 2) ? $clog2(NUM_GAMES) : 1,
    localparam int CW             = $clog2(PROTECT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_start,
    input  logic                 btn_sel,
    input  logic                 btn_pause,
    input  logic                 btn_return,
    input  logic [NUM_GAMES-1:0] gameover,
    output logic [ST_W-1:0]      state,
    output logic [GW-1:0]        game_sel,
    output logic [NUM_GAMES-1:0] enable_game,
    output logic                 enable_my_app,
    output logic                 enable_my_phy,
    output logic                 enable_mybul,
    output logic [N_ENY-1:0]     enable_eny_app,
    output logic [N_ENY-1:0]     enable_eny_phy,
    output logic [N_ENY-1:0]     enable_eny_bul,
    output logic                 enable_reward,
    output logic                 enable_startmusic,
    output logic                 enable_gamemusic,
    output logic                 start_protect
);

    // ---------------- button front end ----------------
    logic [N_BTN-1:0] btn_lvl;
    logic [N_BTN-1:0] btn_pls;

    assign btn_lvl = {btn_return, btn_pause, btn_sel, btn_start};

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_edge u_edge (
            .clk   (clk),
            .rst   (rst),
            .lvl   (btn_lvl[gi]),
            .pulse (btn_pls[gi])
        );
    end

    logic start_e, sel_e, pause_e, ret_e;
    assign start_e = btn_pls[BTN_START];
    assign sel_e   = btn_pls[BTN_SEL];
    assign pause_e = btn_pls[BTN_PAUSE];
    assign ret_e   = btn_pls[BTN_RET];

    // ---------------- state, selection, protect counter ----------------
    state_e          state_q, state_d;
    logic [GW-1:0]   game_sel_q, game_sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            go_hit;

    // Only the selected variant's game-over flag matters.
    always_comb begin
        go_hit = 1'b0;
        for (int g = 0; g < NUM_GAMES; g++) begin
            if (game_sel_q == GW'(g) && gameover[g]) go_hit = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        game_sel_d = game_sel_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_MENU: begin
                cnt_d = '0;
                // start takes priority; selection is left untouched on start
                if (start_e) begin
                    state_d = ST_PLAY;
                end else if (sel_e) begin
                    if (game_sel_q == GW'(NUM_GAMES - 1)) game_sel_d = '0;
                    else                                  game_sel_d = game_sel_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (cnt_q != CW'(PROTECT_CYCLES)) cnt_d = cnt_q + 1'b1;
                if (go_hit)       state_d = ST_OVER;
                else if (pause_e) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                // counter frozen so protect resumes where it stopped
                if (ret_e)        state_d = ST_MENU;
                else if (pause_e) state_d = ST_PLAY;
            end
            ST_OVER: begin
                cnt_d = '0;
                if (ret_e) state_d = ST_MENU;
            end
            default: state_d = ST_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_MENU;
            game_sel_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            game_sel_q <= game_sel_d;
            cnt_q      <= cnt_d;
        end
    end

    // ---------------- registered output decode ----------------
    logic [NUM_GAMES-1:0] enable_game_q, enable_game_d;
    logic                 my_app_q, my_app_d, my_phy_q, my_phy_d, mybul_q, mybul_d;
    logic [N_ENY-1:0]     eny_app_q, eny_app_d, eny_phy_q, eny_phy_d, eny_bul_q, eny_bul_d;
    logic                 reward_q, reward_d, smusic_q, smusic_d, gmusic_q, gmusic_d;
    logic                 protect_q, protect_d;

    always_comb begin
        enable_game_d = '0;
        my_app_d      = 1'b0;
        my_phy_d      = 1'b0;
        mybul_d       = 1'b0;
        eny_app_d     = '0;
        eny_phy_d     = '0;
        eny_bul_d     = '0;
        reward_d      = 1'b0;
        smusic_d      = 1'b0;
        gmusic_d      = 1'b0;
        protect_d     = 1'b0;
        case (state_q)
            ST_MENU: smusic_d = 1'b1;
            ST_PLAY: begin
                for (int g = 0; g < NUM_GAMES; g++) begin
                    enable_game_d[g] = (game_sel_q == GW'(g));
                end
                my_app_d  = 1'b1;
                my_phy_d  = 1'b1;
                mybul_d   = 1'b1;
                eny_app_d = '1;
                eny_phy_d = '1;
                eny_bul_d = '1;
                reward_d  = 1'b1;
                // cnt_q counts PLAY cycles already spent, so this is high
                // for exactly PROTECT_CYCLES PLAY cycles
                protect_d = (cnt_q < CW'(PROTECT_CYCLES));
            end
            ST_PAUSE: begin
                my_app_d  = 1'b1;
                eny_app_d = '1;
                protect_d = protect_q;
            end
            ST_OVER: gmusic_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_game_q <= '0;
            my_app_q      <= 1'b0;
            my_phy_q      <= 1'b0;
            mybul_q       <= 1'b0;
            eny_app_q     <= '0;
            eny_phy_q     <= '0;
            eny_bul_q     <= '0;
            reward_q      <= 1'b0;
            smusic_q      <= 1'b0;
            gmusic_q      <= 1'b0;
            protect_q     <= 1'b0;
        end else begin
            enable_game_q <= enable_game_d;
            my_app_q      <= my_app_d;
            my_phy_q      <= my_phy_d;
            mybul_q       <= mybul_d;
            eny_app_q     <= eny_app_d;
            eny_phy_q     <= eny_phy_d;
            eny_bul_q     <= eny_bul_d;
            reward_q      <= reward_d;
            smusic_q      <= smusic_d;
            gmusic_q      <= gmusic_d;
            protect_q     <= protect_d;
        end
    end

    assign state             = state_q;
    assign game_sel          = game_sel_q;
    assign enable_game       = enable_game_q;
    assign enable_my_app     = my_app_q;
    assign enable_my_phy     = my_phy_q;
    assign enable_mybul      = mybul_q;
    assign enable_eny_app    = eny_app_q;
    assign enable_eny_phy    = eny_phy_q;
    assign enable_eny_bul    = eny_bul_q;
    assign enable_reward     = reward_q;
    assign enable_startmusic = smusic_q;
    assign enable_gamemusic  = gmusic_q;
    assign start_protect     = protect_q;

endmodule
